// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle: decode/execute hazard inputs in, per-stage pipeline
// controls and performance counters out.
interface pipe_hazard_if #(
  parameter int PERF_W = 16
);
  logic [4:0]        D_rs1_i, D_rs2_i;
  logic              D_use_rs1_i, D_use_rs2_i;
  logic [4:0]        E_rd_i;
  logic              E_load_i, E_md_start_i, E_mispredict_i;
  logic              imem_ready_i;
  logic              pc_stall_o, F_stall_o, F_bubble_o;
  logic              D_stall_o, D_bubble_o, E_stall_o, M_bubble_o;
  logic              md_busy_o;
  logic [PERF_W-1:0] stall_cnt_o, flush_cnt_o;

  modport master (
    output D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i, E_rd_i,
           E_load_i, E_md_start_i, E_mispredict_i, imem_ready_i,
    input  pc_stall_o, F_stall_o, F_bubble_o, D_stall_o, D_bubble_o,
           E_stall_o, M_bubble_o, md_busy_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i, E_rd_i,
           E_load_i, E_md_start_i, E_mispredict_i, imem_ready_i,
    output pc_stall_o, F_stall_o, F_bubble_o, D_stall_o, D_bubble_o,
           E_stall_o, M_bubble_o, md_busy_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard control: mul/div occupancy, mispredict flush,
// load-use interlock and imem-miss bubbles, with saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int PERF_W = 16
) (
  input  logic          clk_i,
  input  logic          rst_n,
  pipe_hazard_if.slave  bus
);
  typedef enum logic {RUN, MD_WAIT} state_e;

  localparam logic [2:0]        MD_LOAD = 3'(MD_LAT - 2);
  localparam logic [PERF_W-1:0] CNT_ONE = PERF_W'(1);

  state_e            r_state, w_state_nxt;
  logic [2:0]        r_md_cnt, w_md_cnt_nxt;
  logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_md_hold, w_lu, w_miss, w_flush;
  logic w_pc_stall, w_f_stall, w_f_bubble, w_d_stall, w_d_bubble, w_e_stall, w_m_bubble;

  always_comb begin
    w_md_hold = ((r_state == RUN) && bus.E_md_start_i) ||
                ((r_state == MD_WAIT) && (r_md_cnt != 3'd0));
    w_lu      = bus.E_load_i && (bus.E_rd_i != 5'd0) &&
                ((bus.D_use_rs1_i && (bus.D_rs1_i == bus.E_rd_i)) ||
                 (bus.D_use_rs2_i && (bus.D_rs2_i == bus.E_rd_i)));
    w_miss    = !bus.imem_ready_i;
  end

  // Strict priority: md hold freezes everything upstream, so lower hazards wait.
  always_comb begin
    w_pc_stall = 1'b0; w_f_stall  = 1'b0; w_f_bubble = 1'b0;
    w_d_stall  = 1'b0; w_d_bubble = 1'b0; w_e_stall  = 1'b0;
    w_m_bubble = 1'b0; w_flush    = 1'b0;
    if (w_md_hold) begin
      w_pc_stall = 1'b1; w_f_stall = 1'b1; w_d_stall = 1'b1;
      w_e_stall  = 1'b1; w_m_bubble = 1'b1;
    end else if (bus.E_mispredict_i) begin
      w_f_bubble = 1'b1; w_d_bubble = 1'b1; w_flush = 1'b1;
    end else if (w_lu) begin
      w_pc_stall = 1'b1; w_f_stall = 1'b1; w_d_bubble = 1'b1;
    end else if (w_miss) begin
      w_pc_stall = 1'b1; w_f_bubble = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    case (r_state)
      RUN: if (bus.E_md_start_i) begin
        w_state_nxt  = MD_WAIT;
        w_md_cnt_nxt = MD_LOAD;
      end
      MD_WAIT: begin
        if (r_md_cnt != 3'd0) w_md_cnt_nxt = r_md_cnt - 3'd1;
        else                  w_state_nxt  = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_md_cnt <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_f_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush   && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign bus.pc_stall_o  = w_pc_stall;
  assign bus.F_stall_o   = w_f_stall;
  assign bus.F_bubble_o  = w_f_bubble;
  assign bus.D_stall_o   = w_d_stall;
  assign bus.D_bubble_o  = w_d_bubble;
  assign bus.E_stall_o   = w_e_stall;
  assign bus.M_bubble_o  = w_m_bubble;
  assign bus.md_busy_o   = (r_state == MD_WAIT);
  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.flush_cnt_o = r_flush_cnt;
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline-control block for the five-stage core. It generates the per-stage `*_stall_o` / `*_bubble_o` controls consumed by the F/D/E/M pipeline registers and a PC-hold control for the fetch PC register. It resolves four hazards:

- load-use data hazards,
- branch mispredicts resolved in E,
- instruction-memory wait,
- multi-cycle mul/div occupancy of E.

It sequences the mul/div wait with a small FSM and keeps saturating stall/flush performance counters.

## Interface
**Parameters**
- `MD_LAT`, default 4: total cycles a mul/div instruction occupies E; legal range 2..8.
- `PERF_W`, default 16: width of the performance counters.

**Ports**
- `clk_i`  in  1  — clock; all state updates on the rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `D_rs1_i`, `D_rs2_i`  in  5 each  — source register indices of the instruction in D.
- `D_use_rs1_i`, `D_use_rs2_i`  in  1 each  — the instruction in D actually reads that source.
- `E_rd_i`  in  5  — destination register of the instruction in E.
- `E_load_i`  in  1  — the instruction in E is a load.
- `E_md_start_i`  in  1  — the instruction in E is a mul/div, first cycle in E.
- `E_mispredict_i`  in  1  — the branch in E resolved opposite to the prediction; PC redirects this cycle.
- `imem_ready_i`  in  1  — instruction memory returns a valid instruction this cycle.
- `pc_stall_o`  out  1  — hold the fetch PC.
- `F_stall_o`, `F_bubble_o`  out  1 each  — hold / clear the FD register.
- `D_stall_o`, `D_bubble_o`  out  1 each  — hold / clear the DE register.
- `E_stall_o`  out  1  — hold the EM-side E state.
- `M_bubble_o`  out  1  — insert a nop into the EM register.
- `md_busy_o`  out  1  — FSM is in `MD_WAIT`.
- `stall_cnt_o`  out  `PERF_W`  — cycles with `F_stall_o` = 1, saturating.
- `flush_cnt_o`  out  `PERF_W`  — cycles with `E_mispredict_i` acted on, saturating.

## Operation
**FSM**
- States: `RUN` (reset state) and `MD_WAIT`.
- 3-bit down-counter `md_cnt`, reset value 0.

**Hazard conditions** (evaluated combinationally each cycle)
- `md_hold`:
  - (state = `RUN` and `E_md_start_i`), or
  - (state = `MD_WAIT` and `md_cnt` ≠ 0).
- `lu` (load-use): `E_load_i` and `E_rd_i` ≠ 0 and ((`D_use_rs1_i` and `D_rs1_i` = `E_rd_i`) or (`D_use_rs2_i` and `D_rs2_i` = `E_rd_i`)).
- `miss`: not `imem_ready_i`.

**Priority** (exactly one case applies; all unlisted outputs are 0)
1. `md_hold`: `pc_stall_o`, `F_stall_o`, `D_stall_o`, `E_stall_o`, `M_bubble_o` = 1. A mispredict, load-use or miss in this cycle is ignored; the inputs stay frozen upstream.
2. `E_mispredict_i`: `F_bubble_o` = 1 and `D_bubble_o` = 1. `pc_stall_o` = 0 so the redirect target loads.
3. `lu`: `pc_stall_o`, `F_stall_o`, `D_bubble_o` = 1.
4. `miss`: `pc_stall_o`, `F_bubble_o` = 1.
5. Otherwise: all controls are 0.

**Transitions**
- `RUN` → `MD_WAIT` when `E_md_start_i`; load `md_cnt` = `MD_LAT` − 2.
- `MD_WAIT` with `md_cnt` ≠ 0: decrement `md_cnt`, stay in `MD_WAIT`.
- `MD_WAIT` with `md_cnt` = 0: this is the release cycle. No md stall is asserted, the lower-priority hazards are evaluated normally, and the FSM returns to `RUN`. `E_md_start_i` is ignored in `MD_WAIT`.

**Counters**
- `stall_cnt_o` increments on each cycle with `F_stall_o` = 1.
- `flush_cnt_o` increments on each cycle in which case 2 is selected.
- Both counters saturate at all-ones, i.e. hold at 2^`PERF_W` − 1.

**Reset**
- `rst_n` low forces, asynchronously: state = `RUN`, `md_cnt` = 0, both counters = 0.
- All control outputs then read 0 except as driven by the current-cycle inputs in `RUN`.
- Reset asserted mid-`MD_WAIT` abandons the wait immediately.

## Timing
- All stall/bubble outputs are combinational from the inputs and registered state, with zero-cycle latency, and are valid before the same rising edge they act on.
- A mul/div stays in E for exactly `MD_LAT` cycles, of which the first `MD_LAT` − 1 are stalled.
- With `MD_LAT` = 2: one stall cycle (the `RUN` cycle); `MD_WAIT` is entered with `md_cnt` = 0 and releases at once.
- Load-use inserts exactly one bubble. In the following cycle the load has moved to M, so `lu` = 0 unless a new load has arrived in E.
- A miss holds for as many cycles as `imem_ready_i` stays low; each such cycle produces one FD bubble.
- Counters update on the rising edge following the qualifying cycle.
- `md_busy_o` is registered: it is 1 from the cycle after the start through the release cycle inclusive.

## Test plan
- **Reset:** drive `rst_n` low for 3 cycles with random inputs toggling → counters = 0, `md_busy_o` = 0. After release with all inputs idle and `imem_ready_i` = 1 → all controls = 0.
- **Load-use:** `E_load_i` = 1, `E_rd_i` = 5, `D_rs2_i` = 5, `D_use_rs2_i` = 1 → `pc_stall_o`, `F_stall_o`, `D_bubble_o` = 1 for one cycle; `stall_cnt_o` = 1. Repeat with `E_rd_i` = 0 → no stall.
- **Mul/div:** `MD_LAT` = 4, pulse `E_md_start_i` → `F_stall_o`, `D_stall_o`, `E_stall_o`, `M_bubble_o` = 1 for exactly 3 cycles, 0 in the 4th; `md_busy_o` = 1 in cycles 2–4; `stall_cnt_o` = 3.
- **Simultaneous events:** `E_mispredict_i`, `lu` and `miss` in the same cycle → only `F_bubble_o` = `D_bubble_o` = 1 and `pc_stall_o` = 0; `flush_cnt_o` += 1. The same combination asserted during `MD_WAIT` (`md_cnt` ≠ 0) → md stall outputs only, and `flush_cnt_o` unchanged.
- **Saturation and miss:** `PERF_W` = 4, 20 consecutive load-use cycles → `stall_cnt_o` stops at 15. Hold `imem_ready_i` low for 5 cycles → `F_bubble_o` and `pc_stall_o` = 1 for exactly 5 cycles.
- **Reset mid-wait:** drop `rst_n` in the second `MD_WAIT` cycle → `md_busy_o` = 0 immediately. After release, a stall appears only on a new `E_md_start_i`.
